// File: rtl/div_dispatch_scheduler.sv
// div_dispatch_scheduler: round-robin divider dispatch with thermometer tags, in-flight window and flush drain.
// Defining DISPATCH_PERF_CNT_EN adds a saturating stall-cycle counter output.
`ifndef TAG_SIZE
`define TAG_SIZE 8
`endif
module div_dispatch_scheduler #(
  parameter int DIV_COUNT = 16,
  parameter int TAG_SIZE = `TAG_SIZE,
  parameter int MAX_OUTSTANDING = TAG_SIZE - 1,
  localparam int OW = $clog2(MAX_OUTSTANDING + 1),
  localparam int PW = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid_in,
  output logic                 req_ready_out,
  input  logic [DIV_COUNT-1:0] div_busy_in,
  input  logic [DIV_COUNT-1:0] fifo_overflow_in,
  output logic [DIV_COUNT-1:0] issue_valid_out,
  output logic [TAG_SIZE-1:0]  issue_tag_out,
  input  logic                 retire_valid_in,
  input  logic                 flush_in,
  output logic [OW-1:0]        outstanding_out,
  output logic                 draining_out,
`ifdef DISPATCH_PERF_CNT_EN
  output logic [31:0]          perf_stall_cycles_out,
`endif
  output logic                 error_out
);
  typedef enum logic {RUN, DRAIN} state_t;
  state_t state, state_nxt;
  logic [PW-1:0] rr_ptr, grant, rr_nxt;
  logic [TAG_SIZE-1:0] tag, tag_nxt;
  logic [DIV_COUNT-1:0] elig;
  logic found, accept, restart;
  int j;
  assign elig = ~div_busy_in & ~fifo_overflow_in;
  // Scan lanes starting at rr_ptr, wrapping, and take the first eligible one.
  always_comb begin
    found = 1'b0;
    grant = '0;
    j = 0;
    for (int k = 0; k < DIV_COUNT; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= DIV_COUNT) j = j - DIV_COUNT;
      if (!found && elig[j]) begin
        found = 1'b1;
        grant = PW'(j);
      end
    end
  end
  assign req_ready_out = reset_n && state == RUN && outstanding_out < OW'(MAX_OUTSTANDING) && found;
  assign accept = req_valid_in && req_ready_out && !flush_in;
  assign restart = state == DRAIN && outstanding_out == '0;
  assign rr_nxt = (grant == PW'(DIV_COUNT - 1)) ? '0 : grant + PW'(1);
  assign tag_nxt = (&tag) ? TAG_SIZE'(1) : {tag[TAG_SIZE-2:0], 1'b1};
  assign draining_out = state == DRAIN;
  always_comb begin
    state_nxt = state;
    state_nxt = (state == RUN) ? (flush_in ? DRAIN : RUN) : (restart ? RUN : DRAIN);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      rr_ptr <= '0;
      tag <= TAG_SIZE'(1);
      outstanding_out <= '0;
      issue_valid_out <= '0;
      issue_tag_out <= '0;
      error_out <= 1'b0;
    end else begin
      state <= state_nxt;
      issue_valid_out <= accept ? (DIV_COUNT'(1) << grant) : '0;
      if (accept) issue_tag_out <= tag;
      rr_ptr <= restart ? '0 : (accept ? rr_nxt : rr_ptr);
      tag <= restart ? TAG_SIZE'(1) : (accept ? tag_nxt : tag);
      if (accept && !retire_valid_in) outstanding_out <= outstanding_out + OW'(1);
      else if (retire_valid_in && !accept) begin
        if (outstanding_out == '0) error_out <= 1'b1;
        else outstanding_out <= outstanding_out - OW'(1);
      end
    end
  end
`ifdef DISPATCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) perf_stall_cycles_out <= '0;
    else if (req_valid_in && !req_ready_out && !(&perf_stall_cycles_out))
      perf_stall_cycles_out <= perf_stall_cycles_out + 32'd1;
  end
`endif
endmodule

// File: tb/tb_div_dispatch_scheduler.sv
// tb_div_dispatch_scheduler: directed scenarios plus random traffic against a cycle-level behavioural model.
module tb_div_dispatch_scheduler;
  localparam int N = 16, T = 8, M = 7, OW = $clog2(M + 1);
  logic clk = 0, reset_n = 0, req_valid_in = 0, retire_valid_in = 0, flush_in = 0;
  logic [N-1:0] div_busy_in = '0, fifo_overflow_in = '0;
  logic req_ready_out, draining_out, error_out;
  logic [N-1:0] issue_valid_out;
  logic [T-1:0] issue_tag_out;
  logic [OW-1:0] outstanding_out;
`ifdef DISPATCH_PERF_CNT_EN
  logic [31:0] perf_stall_cycles_out;
`endif
  int checks = 0, errors = 0;
  bit m_drain, m_err, e_ready, obs_ready;
  int m_rr, m_tagn, m_out;
  logic [N-1:0] e_iv;
  logic [T-1:0] e_tag;

  always #5 clk = ~clk;

  div_dispatch_scheduler #(.DIV_COUNT(N), .TAG_SIZE(T), .MAX_OUTSTANDING(M)) dut (
    .clk(clk), .reset_n(reset_n), .req_valid_in(req_valid_in), .req_ready_out(req_ready_out),
    .div_busy_in(div_busy_in), .fifo_overflow_in(fifo_overflow_in), .issue_valid_out(issue_valid_out),
    .issue_tag_out(issue_tag_out), .retire_valid_in(retire_valid_in), .flush_in(flush_in),
    .outstanding_out(outstanding_out), .draining_out(draining_out),
`ifdef DISPATCH_PERF_CNT_EN
    .perf_stall_cycles_out(perf_stall_cycles_out),
`endif
    .error_out(error_out));

  task automatic model_reset();
    m_drain = 0; m_err = 0; m_rr = 0; m_tagn = 0; m_out = 0; e_iv = '0; e_tag = '0;
  endtask

  // One clock of stimulus; predicts ready before the edge and all registered outputs after it.
  task automatic step(input bit v, input logic [N-1:0] b, input logic [N-1:0] o, input bit r, input bit f);
    logic [N-1:0] el;
    logic [T-1:0] th;
    int g, old;
    bit acc;
    @(negedge clk);
    req_valid_in = v; div_busy_in = b; fifo_overflow_in = o; retire_valid_in = r; flush_in = f;
    el = ~b & ~o;
    e_ready = !m_drain && m_out < M && el != '0;
    acc = v && e_ready && !f;
    g = -1;
    for (int k = 0; k < N; k++) if (g < 0 && el[(m_rr + k) % N]) g = (m_rr + k) % N;
    #1 obs_ready = req_ready_out;
    @(posedge clk);
    old = m_out;
    e_iv = '0;
    if (acc) begin
      th = '0;
      for (int i = 0; i <= m_tagn; i++) th[i] = 1'b1;
      e_iv[g] = 1'b1;
      e_tag = th;
      m_tagn = (m_tagn + 1) % T;
      m_rr = (g + 1) % N;
    end
    if (acc && !r) m_out++;
    else if (r && !acc) begin
      if (m_out == 0) m_err = 1;
      else m_out--;
    end
    if (!m_drain && f) m_drain = 1;
    else if (m_drain && old == 0) begin
      m_drain = 0; m_tagn = 0; m_rr = 0;
    end
    #1;
  endtask

  task automatic test_reset();
    reset_n = 0;
    model_reset();
    #12;
    checks++; if (req_ready_out !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", req_ready_out); end
    checks++; if (issue_valid_out !== '0 || issue_tag_out !== '0) begin errors++; $display("FAIL reset_issue got %h/%h exp 0/0", issue_valid_out, issue_tag_out); end
    checks++; if (outstanding_out !== '0 || error_out !== 1'b0 || draining_out !== 1'b0) begin errors++; $display("FAIL reset_state got out=%0d err=%b drn=%b exp 0/0/0", outstanding_out, error_out, draining_out); end
    @(negedge clk) reset_n = 1;
  endtask

  task automatic test_round_robin();
    logic [N-1:0] oh;
    logic [T-1:0] tg;
    for (int i = 0; i < 17; i++) begin
      step(1, '0, '0, i > 0, 0);
      oh = '0; oh[i % N] = 1'b1;
      tg = '0;
      for (int k = 0; k <= i % T; k++) tg[k] = 1'b1;
      checks++; if (issue_valid_out !== oh) begin errors++; $display("FAIL rr_lane[%0d] got %h exp %h", i, issue_valid_out, oh); end
      checks++; if (issue_tag_out !== tg) begin errors++; $display("FAIL rr_tag[%0d] got %h exp %h", i, issue_tag_out, tg); end
    end
    step(0, '0, '0, 0, 0);
    checks++; if (issue_valid_out !== '0 || issue_tag_out !== 8'h01) begin errors++; $display("FAIL idle_hold got %h/%h exp 0/01", issue_valid_out, issue_tag_out); end
    checks++; if (outstanding_out !== OW'(1)) begin errors++; $display("FAIL rr_outstanding got %0d exp 1", outstanding_out); end
  endtask

  task automatic test_lane_skip();
    step(0, '0, '0, 1, 0);
    step(1, 16'h0002, '0, 0, 0);
    checks++; if (issue_valid_out !== 16'h0004) begin errors++; $display("FAIL skip_lane got %h exp 0004", issue_valid_out); end
    step(1, '0, '0, 1, 0);
    checks++; if (issue_valid_out !== 16'h0008) begin errors++; $display("FAIL skip_rrptr got %h exp 0008", issue_valid_out); end
    step(1, '0, 16'hFFF0, 0, 0);
    checks++; if (issue_valid_out !== 16'h0001) begin errors++; $display("FAIL skip_wrap got %h exp 0001", issue_valid_out); end
  endtask

  task automatic test_window_full();
    while (m_out < M) step(1, '0, '0, 0, 0);
    step(1, '0, '0, 0, 0);
    checks++; if (obs_ready !== 1'b0 || issue_valid_out !== '0) begin errors++; $display("FAIL full_ready got %b/%h exp 0/0", obs_ready, issue_valid_out); end
    checks++; if (outstanding_out !== OW'(M)) begin errors++; $display("FAIL full_count got %0d exp %0d", outstanding_out, M); end
    step(0, '0, '0, 1, 0);
    step(1, '0, '0, 1, 0);
    checks++; if (obs_ready !== 1'b1 || issue_valid_out === '0) begin errors++; $display("FAIL reopen got %b/%h exp 1/issue", obs_ready, issue_valid_out); end
    checks++; if (outstanding_out !== OW'(M - 1)) begin errors++; $display("FAIL acc_ret got %0d exp %0d", outstanding_out, M - 1); end
    step(1, '0, '0, 0, 0);
    step(1, '0, '1, 0, 0);
    checks++; if (obs_ready !== 1'b0) begin errors++; $display("FAIL no_lane_ready got %b exp 0", obs_ready); end
  endtask

  task automatic test_flush();
    while (m_out > 3) step(0, '0, '0, 1, 0);
    step(1, '0, '0, 0, 1);
    checks++; if (issue_valid_out !== '0 || draining_out !== 1'b1 || outstanding_out !== OW'(3)) begin errors++; $display("FAIL flush_enter got %h/%b/%0d exp 0/1/3", issue_valid_out, draining_out, outstanding_out); end
    for (int i = 0; i < 3; i++) begin
      step(1, '0, '0, 1, 0);
      checks++; if (obs_ready !== 1'b0 || draining_out !== 1'b1) begin errors++; $display("FAIL drain[%0d] got rdy=%b drn=%b exp 0/1", i, obs_ready, draining_out); end
    end
    step(1, '0, '0, 0, 0);
    checks++; if (obs_ready !== 1'b0 || draining_out !== 1'b0 || issue_valid_out !== '0) begin errors++; $display("FAIL drain_exit got %b/%b/%h exp 0/0/0", obs_ready, draining_out, issue_valid_out); end
    step(1, '0, '0, 0, 0);
    checks++; if (issue_valid_out !== 16'h0001 || issue_tag_out !== 8'h01) begin errors++; $display("FAIL flush_restart got %h/%h exp 0001/01", issue_valid_out, issue_tag_out); end
    step(0, '0, '0, 0, 1);
    step(0, '0, '0, 1, 1);
    checks++; if (draining_out !== 1'b1 || outstanding_out !== '0) begin errors++; $display("FAIL flush_in_drain got %b/%0d exp 1/0", draining_out, outstanding_out); end
    step(0, '0, '0, 0, 0);
    checks++; if (draining_out !== 1'b0) begin errors++; $display("FAIL drain_leave got %b exp 0", draining_out); end
    step(0, '0, '0, 0, 1);
    checks++; if (draining_out !== 1'b1) begin errors++; $display("FAIL zero_flush got %b exp 1", draining_out); end
    step(0, '0, '0, 0, 0);
    checks++; if (draining_out !== 1'b0) begin errors++; $display("FAIL zero_flush_one got %b exp 0", draining_out); end
  endtask

  task automatic test_underflow();
    step(0, '0, '0, 1, 0);
    checks++; if (error_out !== 1'b1 || outstanding_out !== '0) begin errors++; $display("FAIL underflow got err=%b out=%0d exp 1/0", error_out, outstanding_out); end
    step(1, '0, '0, 0, 0);
    step(0, '0, '0, 0, 0);
    checks++; if (error_out !== 1'b1 || outstanding_out !== OW'(1)) begin errors++; $display("FAIL err_sticky got err=%b out=%0d exp 1/1", error_out, outstanding_out); end
  endtask

  task automatic test_reset_mid();
    step(1, '0, '0, 0, 0);
    reset_n = 0;
    #1;
    checks++; if (issue_valid_out !== '0 || issue_tag_out !== '0 || req_ready_out !== 1'b0) begin errors++; $display("FAIL mid_reset_io got %h/%h/%b exp 0/0/0", issue_valid_out, issue_tag_out, req_ready_out); end
    checks++; if (outstanding_out !== '0 || error_out !== 1'b0 || draining_out !== 1'b0) begin errors++; $display("FAIL mid_reset_st got %0d/%b/%b exp 0/0/0", outstanding_out, error_out, draining_out); end
    model_reset();
    req_valid_in = 0; retire_valid_in = 0; flush_in = 0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    @(posedge clk) #1;
    checks++; if (issue_valid_out !== '0) begin errors++; $display("FAIL release_strobe got %h exp 0", issue_valid_out); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(3) != 0, N'($urandom & $urandom), N'($urandom & $urandom & $urandom),
           $urandom_range(2) == 0, $urandom_range(31) == 0);
      checks++; if (obs_ready !== e_ready) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", i, obs_ready, e_ready); end
      checks++; if (issue_valid_out !== e_iv || issue_tag_out !== e_tag) begin errors++; $display("FAIL rnd_issue[%0d] got %h/%h exp %h/%h", i, issue_valid_out, issue_tag_out, e_iv, e_tag); end
      checks++; if (outstanding_out !== OW'(m_out) || draining_out !== m_drain || error_out !== m_err) begin errors++; $display("FAIL rnd_state[%0d] got %0d/%b/%b exp %0d/%b/%b", i, outstanding_out, draining_out, error_out, m_out, m_drain, m_err); end
    end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lane_skip();
    test_window_full();
    test_flush();
    test_underflow();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
